// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the slave memory and its benches.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] BYTE  = 3'd0;
  localparam logic [2:0] HALF  = 3'd1;
  localparam logic [2:0] WORD  = 3'd2;
  localparam logic [2:0] DWORD = 3'd3;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Little-endian byte lanes touched by a transfer of 2**size bytes at offset.
  function automatic logic [7:0] lane_mask(input logic [2:0] offset, input logic [2:0] size);
    logic [7:0] mask;
    int nbytes;
    mask   = '0;
    nbytes = 1 << size;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (i >= int'(offset)) && (i < int'(offset) + nbytes);
    end
    return mask;
  endfunction

  // Low address bits that must be zero for a naturally aligned transfer.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    logic [2:0] mask;
    case (size)
      BYTE:    mask = 3'b000;
      HALF:    mask = 3'b001;
      WORD:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_slv_ram.sv
// Byte-enable word array: one synchronous write port, one combinational read port.
module ahb_slv_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         hclk,
  input  logic                         we,
  input  logic [DATA_WIDTH/8-1:0]      be,
  input  logic [$clog2(MEM_DEPTH)-1:0] widx,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0] ridx,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge hclk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_slv_mem.sv
// AHB-Lite slave memory: configurable wait states, byte-lane writes,
// registered reads with write forwarding, and a two-cycle ERROR response.
module ahb_slv_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int         BYTES    = DATA_WIDTH / 8;
  localparam int         OFF_W    = $clog2(BYTES);
  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam int         HI       = OFF_W + IDX_W;
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);
  localparam logic [2:0] WS_LAST  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  slv_state_e            state, next_state;
  logic [2:0]            wait_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic [BYTES-1:0]      be_q;
  logic                  write_q;
  logic                  accept, illegal, wr_commit;
  logic [IDX_W-1:0]      a_idx;
  logic [2:0]            a_off;
  logic [7:0]            a_mask;
  logic [DATA_WIDTH-1:0] ram_rdata, fwd_data;
  logic                  unused_bits;

  assign unused_bits = ^{hburst, htrans[0], a_mask};

  // Address-phase decode; hreadyout gates sampling so WAIT/ERR1 never accept.
  always_comb begin
    a_idx   = haddr[HI-1:OFF_W];
    a_off   = 3'(haddr[OFF_W-1:0]);
    a_mask  = lane_mask(a_off, hsize);
    accept  = hsel && hready && htrans[1] && hreadyout;
    illegal = (hsize > MAX_SIZE) ||
              (|(haddr[2:0] & align_mask(hsize))) ||
              (|(haddr >> HI));
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!accept)                next_state = ST_IDLE;
        else if (illegal)           next_state = ST_ERR1;
        else if (WAIT_STATES > 0)   next_state = ST_WAIT;
        else                        next_state = ST_DATA;
      end
      ST_WAIT: if (wait_cnt == WS_LAST) next_state = ST_DATA;
      ST_ERR1: next_state = ST_ERR2;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = !(state == ST_WAIT || state == ST_ERR1);
    hresp     = (state == ST_ERR1 || state == ST_ERR2) ? ERROR : OKAY;
  end

  // Captured transfer; an erroring or aborted transfer leaves write_q clear.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      wait_cnt <= 3'd0;
      idx_q    <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
    end else begin
      if (state == ST_WAIT && wait_cnt != WS_LAST) wait_cnt <= wait_cnt + 3'd1;
      else                                         wait_cnt <= 3'd0;
      if (accept) begin
        write_q <= hwrite && !illegal;
        if (!illegal) begin
          idx_q <= a_idx;
          be_q  <= a_mask[BYTES-1:0];
        end
      end else if (state == ST_DATA) begin
        write_q <= 1'b0;
      end
    end
  end

  assign wr_commit = (state == ST_DATA) && write_q;

  // A read accepted on the same edge a write to that word commits sees the new bytes.
  always_comb begin
    fwd_data = ram_rdata;
    if (wr_commit && idx_q == a_idx) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) fwd_data[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst)                              hrdata <= '0;
    else if (accept && !illegal && !hwrite) hrdata <= fwd_data;
  end

  ahb_slv_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .hclk (hclk),
    .we   (wr_commit),
    .be   (be_q),
    .widx (idx_q),
    .wdata(hwdata),
    .ridx (a_idx),
    .rdata(ram_rdata)
  );

endmodule
